// File: rtl/cal_angle_div_pkg.sv
// cal_angle_div_pkg: shared widths and defaults for the divider arbiter
package cal_angle_div_pkg;
    localparam int DIVIDEND_W  = 16;
    localparam int DIVISOR_W   = 8;
    localparam int RES_W       = 24;
    localparam int NUM_REQ_DEF = 4;
    localparam int TAG_W_DEF   = $clog2(NUM_REQ_DEF);

    // Tag width for a given requester count, never narrower than one bit
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/div_tag_fifo.sv
// div_tag_fifo: outstanding-tag FIFO remembering which requester owns each in-flight division
module div_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointer and occupancy update; overflow and underflow requests are ignored
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer/count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Tag storage needs no reset: only entries below the count are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/cal_angle_div_arbiter.sv
// cal_angle_div_arbiter: round-robin sharing of one fixed-latency divider with in-order result routing
module cal_angle_div_arbiter
    import cal_angle_div_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int TAG_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_val_i,
    input  logic [NUM_REQ*DIVIDEND_W-1:0] req_dividend_i,
    input  logic [NUM_REQ*DIVISOR_W-1:0]  req_divisor_i,
    output logic [NUM_REQ-1:0]            req_rdy_o,
    output logic                          div_val_o,
    output logic [DIVIDEND_W-1:0]         div_dividend_o,
    output logic [DIVISOR_W-1:0]          div_divisor_o,
    input  logic                          div_val_i,
    input  logic [RES_W-1:0]              div_res_i,
    output logic [NUM_REQ-1:0]            res_val_o,
    output logic [RES_W-1:0]              res_data_o,
    output logic                          busy_o,
    output logic                          err_o
);
    localparam int TW = tag_w(NUM_REQ);
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    logic [TW-1:0]         rr_q, rr_d, gidx, j, head_tag;
    logic [NUM_REQ-1:0]    grant, res_val_q, res_val_d;
    logic                  accept, pop, fifo_full, fifo_empty;
    logic [CW-1:0]         count;
    logic                  div_val_q, div_val_d, busy_q, busy_d, err_q, err_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [RES_W-1:0]      res_q, res_d;

    div_tag_fifo #(.WIDTH(TW), .DEPTH(TAG_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .din_i   (gidx),
        .pop_i   (pop),
        .dout_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // Round-robin grant: scan backwards so the first valid requester from rr_q wins
    always_comb begin
        grant = '0;
        gidx  = rr_q;
        j     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = TW'((int'(rr_q) + i) % NUM_REQ);
            if (req_val_i[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                gidx     = j;
            end
        end
        req_rdy_o = grant & {NUM_REQ{rst_n && !fifo_full}};
        accept    = |req_rdy_o;
    end

    // Issue, result routing, error and busy next-state
    always_comb begin
        pop       = div_val_i && !fifo_empty;
        rr_d      = accept ? ((gidx == TW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1) : rr_q;
        div_val_d = accept;
        dvd_d     = accept ? req_dividend_i[int'(gidx)*DIVIDEND_W +: DIVIDEND_W] : dvd_q;
        dvs_d     = accept ? req_divisor_i[int'(gidx)*DIVISOR_W +: DIVISOR_W] : dvs_q;
        res_val_d = pop ? (NUM_REQ'(1) << head_tag) : '0;
        res_d     = pop ? div_res_i : res_q;
        err_d     = err_q || (div_val_i && fifo_empty);
        busy_d    = ((count + CW'(accept) - CW'(pop)) != '0) || div_val_d;
    end

    // Registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            div_val_q <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            res_val_q <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            div_val_q <= div_val_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            res_val_q <= res_val_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign div_val_o      = div_val_q;
    assign div_dividend_o = dvd_q;
    assign div_divisor_o  = dvs_q;
    assign res_val_o      = res_val_q;
    assign res_data_o     = res_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_cal_angle_div_arbiter.sv
// tb_cal_angle_div_arbiter: directed vectors plus multi-cycle sequences against a queue-based divider model
module tb_cal_angle_div_arbiter;
    import cal_angle_div_pkg::*;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_val = '0;
    logic [N*16-1:0] req_dvd;
    logic [N*8-1:0]  req_dvs;
    logic [N-1:0]    rdy;
    logic            div_val_o;
    logic [15:0]     div_dvd;
    logic [7:0]      div_dvs;
    logic            div_val_i = 1'b0;
    logic [23:0]     div_res = '0;
    logic [N-1:0]    res_val;
    logic [23:0]     res_data;
    logic            busy, err;

    logic [15:0] op_dvd [N];
    logic [7:0]  op_dvs [N];

    int n_cmp = 0, n_bad = 0, cyc = 0, lat = 3, dv_pulses = 0, acc_cnt = 0;
    bit stall = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < N; g++) begin : g_pack
        assign req_dvd[g*16 +: 16] = op_dvd[g];
        assign req_dvs[g*8 +: 8]   = op_dvs[g];
    end

    cal_angle_div_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_val_i      (req_val),
        .req_dividend_i (req_dvd),
        .req_divisor_i  (req_dvs),
        .req_rdy_o      (rdy),
        .div_val_o      (div_val_o),
        .div_dividend_o (div_dvd),
        .div_divisor_o  (div_dvs),
        .div_val_i      (div_val_i),
        .div_res_i      (div_res),
        .res_val_o      (res_val),
        .res_data_o     (res_data),
        .busy_o         (busy),
        .err_o          (err)
    );

    function automatic logic [23:0] div_model(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] q, r;
        if (b == 8'd0) return {16'hFFFF, a[7:0]};
        q = a / {8'd0, b};
        r = a % {8'd0, b};
        return {q, r[7:0]};
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // In-order fixed-latency divider; it keeps running through DUT reset
    typedef struct {int due; logic [23:0] d;} dq_t;
    dq_t dq[$];
    always @(posedge clk) begin
        dq_t e;
        #3;
        if (div_val_o) begin
            e.due = cyc + lat;
            e.d   = div_model(div_dvd, div_dvs);
            dq.push_back(e);
        end
        if (!stall && dq.size() > 0 && dq[0].due <= cyc) begin
            div_val_i = 1'b1;
            div_res   = dq[0].d;
            void'(dq.pop_front());
            dv_pulses++;
        end else begin
            div_val_i = 1'b0;
        end
    end

    logic [N-1:0] rv_log[$];
    logic [23:0]  rd_log[$];
    always @(negedge clk) begin
        if (res_val != '0) begin
            rv_log.push_back(res_val);
            rd_log.push_back(res_data);
        end
        if (rdy != '0) acc_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_val = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_res(input int n, input int budget);
        int w = 0;
        while (rv_log.size() < n && w < budget) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (rv_log.size() < n) check("result_timeout", rv_log.size(), n);
    endtask

    task automatic check_route(input int base, input int idx, input int req);
        if (base + idx >= rv_log.size()) begin
            check("route_missing", rv_log.size(), base + idx + 1);
        end else begin
            check("route_req", rv_log[base+idx], N'(1) << req);
            check("route_data", rd_log[base+idx], div_model(op_dvd[req], op_dvs[req]));
        end
    endtask

    typedef struct packed {logic [N-1:0] val; logic [N-1:0] rdy;} vec_t;
    vec_t tbl[10];
    int   exp_order[$];
    int   rbase, a0, p0, idx;

    initial begin
        op_dvd[0] = 16'd500;   op_dvs[0] = 8'd3;
        op_dvd[1] = 16'd60000; op_dvs[1] = 8'd200;
        op_dvd[2] = 16'd1000;  op_dvs[2] = 8'd7;
        op_dvd[3] = 16'd12345; op_dvs[3] = 8'd99;
        tbl[0] = {4'b1111, 4'b0001};
        tbl[1] = {4'b0001, 4'b0001};
        tbl[2] = {4'b1000, 4'b1000};
        tbl[3] = {4'b0110, 4'b0010};
        tbl[4] = {4'b0000, 4'b0000};
        tbl[5] = {4'b0011, 4'b0001};
        tbl[6] = {4'b1100, 4'b0100};
        tbl[7] = {4'b0111, 4'b0001};
        tbl[8] = {4'b1010, 4'b0010};
        tbl[9] = {4'b1010, 4'b1000};

        // Reset values with requests pending
        req_val = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", rdy, 0);
        check("rst_div_val", div_val_o, 0);
        check("rst_dvd", div_dvd, 0);
        check("rst_dvs", div_dvs, 0);
        check("rst_res_val", res_val, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        req_val = '0;
        rst_n = 1'b1;

        // Table-driven round-robin arbitration and issue
        rbase = rv_log.size();
        for (int i = 0; i < 10; i++) begin
            req_val = tbl[i].val;
            @(negedge clk);
            check("arb_rdy", rdy, tbl[i].rdy);
            tick();
            check("issue_val", div_val_o, |tbl[i].rdy);
            if (tbl[i].rdy != '0) begin
                idx = oh2i(tbl[i].rdy);
                check("issue_dvd", div_dvd, op_dvd[idx]);
                check("issue_dvs", div_dvs, op_dvs[idx]);
                exp_order.push_back(idx);
            end
        end
        req_val = '0;
        wait_res(rbase + 9, 60);
        foreach (exp_order[k]) check_route(rbase, k, exp_order[k]);
        tick();
        check("tbl_idle_busy", busy, 0);
        check("tbl_res_hold", res_data, div_model(op_dvd[3], op_dvs[3]));
        check("tbl_err", err, 0);

        // Single request, requester 2, 1000/7, latency 20
        lat = 20;
        req_val = 4'b0100;
        @(negedge clk);
        check("single_rdy", rdy, 4'b0100);
        tick();
        req_val = '0;
        check("single_issue", div_val_o, 1);
        check("single_dvd", div_dvd, 16'd1000);
        check("single_dvs", div_dvs, 8'd7);
        check("single_busy", busy, 1);
        for (int w = 0; w < 60 && !div_val_i; w++) @(negedge clk);
        check("single_div_seen", div_val_i, 1);
        check("single_res_early", res_val, 0);
        @(negedge clk);
        check("single_res_val", res_val, 4'b0100);
        check("single_res_data", res_data, 24'h008E06);
        @(negedge clk);
        check("single_res_pulse", res_val, 0);
        check("single_res_hold", res_data, 24'h008E06);

        // All four held valid for 8 cycles from a fresh pointer
        do_reset();
        rbase = rv_log.size();
        req_val = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr8_rdy", rdy, N'(1) << (i % 4));
            tick();
        end
        req_val = '0;
        wait_res(rbase + 8, 80);
        for (int k = 0; k < 8; k++) check_route(rbase, k, k % 4);

        // Stalled divider fills the tag FIFO
        do_reset();
        lat = 3;
        stall = 1;
        rbase = rv_log.size();
        a0 = acc_cnt;
        req_val = 4'hF;
        repeat (40) tick();
        @(negedge clk);
        check("full_accepts", acc_cnt - a0, 32);
        check("full_rdy", rdy, 0);
        check("full_busy", busy, 1);
        tick();
        stall = 0;
        @(negedge clk);
        check("full_pop_seen", div_val_i, 1);
        check("full_pop_same_rdy", rdy, 0);
        @(negedge clk);
        check("full_resume_rdy", rdy, 4'b0001);
        tick();
        req_val = '0;
        wait_res(rbase + 33, 200);
        for (int k = 0; k < 33; k++) check_route(rbase, k, k % 4);
        tick();
        check("full_idle_busy", busy, 0);

        // Simultaneous push and pop at count 5
        do_reset();
        lat = 2;
        stall = 1;
        rbase = rv_log.size();
        req_val = 4'b0001; tick();
        req_val = 4'b0010; tick();
        req_val = 4'b0100; tick();
        req_val = 4'b1000; tick();
        req_val = 4'b0001; tick();
        req_val = '0;
        tick();
        check("pp_count_before", dut.u_fifo.cnt_q, 5);
        stall = 0;
        req_val = 4'b0010;
        @(negedge clk);
        check("pp_pop", div_val_i, 1);
        check("pp_push", rdy, 4'b0010);
        tick();
        req_val = '0;
        check("pp_count_after", dut.u_fifo.cnt_q, 5);
        wait_res(rbase + 6, 40);
        check_route(rbase, 0, 0);
        check_route(rbase, 1, 1);
        check_route(rbase, 2, 2);
        check_route(rbase, 3, 3);
        check_route(rbase, 4, 0);
        check_route(rbase, 5, 1);

        // Reset with three operations in flight
        do_reset();
        lat = 10;
        rbase = rv_log.size();
        p0 = dv_pulses;
        req_val = 4'b0001; tick();
        req_val = 4'b0010; tick();
        req_val = 4'b0100; tick();
        req_val = '0;
        tick();
        req_val = 4'hF;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rdy", rdy, 0);
        check("mid_rst_div_val", div_val_o, 0);
        check("mid_rst_dvd", div_dvd, 0);
        check("mid_rst_res_val", res_val, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", dut.u_fifo.cnt_q, 0);
        tick();
        req_val = '0;
        rst_n = 1'b1;
        repeat (20) tick();
        check("late_pulses", dv_pulses - p0, 3);
        check("late_dropped", rv_log.size(), rbase);
        check("late_err", err, 1);
        repeat (5) tick();
        check("late_err_sticky", err, 1);

        // Divisor zero is forwarded unchanged
        do_reset();
        check("err_cleared", err, 0);
        op_dvd[1] = 16'd777;
        op_dvs[1] = 8'd0;
        rbase = rv_log.size();
        req_val = 4'b0010;
        @(negedge clk);
        check("dz_rdy", rdy, 4'b0010);
        tick();
        req_val = '0;
        check("dz_issue", div_val_o, 1);
        check("dz_dvs", div_dvs, 0);
        check("dz_dvd", div_dvd, 16'd777);
        wait_res(rbase + 1, 40);
        if (rv_log.size() > rbase) begin
            check("dz_res_val", rv_log[rbase], 4'b0010);
            check("dz_res_data", rd_log[rbase], 24'hFFFF09);
        end
        check("dz_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cal_angle_div_arbiter.md
CAL_ANGLE_DIV_ARBITER -- requirements
Module: cal_angle_div_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one divider (2..8).
REQ-002 SHALL have parameter TAG_DEPTH, default 32, number of outstanding-tag FIFO entries (power of 2, at least the divider latency + 2).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_val_i, input, NUM_REQ, per-requester operand valid.
REQ-007 SHALL have port req_dividend_i, input, NUM_REQ*16, packed dividends (requester k at bits [16k+15:16k]).
REQ-008 SHALL have port req_divisor_i, input, NUM_REQ*8, packed divisors (requester k at bits [8k+7:8k]).
REQ-009 SHALL have port req_rdy_o, output, NUM_REQ, one-hot-or-zero accept, combinational from registered state and req_val_i.
REQ-010 SHALL have port div_val_o, output, 1, drives the divider dividend and divisor tvalid.
REQ-011 SHALL have port div_dividend_o, output, 16, divider dividend.
REQ-012 SHALL have port div_divisor_o, output, 8, divider divisor.
REQ-013 SHALL have port div_val_i, input, 1, divider dout tvalid.
REQ-014 SHALL have port div_res_i, input, 24, divider dout tdata.
REQ-015 SHALL have port res_val_o, output, NUM_REQ, one-hot result strobe to the owning requester.
REQ-016 SHALL have port res_data_o, output, 24, result data, shared by all requesters.
REQ-017 SHALL have port busy_o, output, 1, asserted when any operation is issued or outstanding.
REQ-018 SHALL have port err_o, output, 1, sticky error: a result arrived while no tag was outstanding.

Function
REQ-019 Accept on requester k occurs in a cycle where req_val_i[k] and req_rdy_o[k] are both 1; at most one accept per cycle.
REQ-020 Arbitration SHALL be round-robin:
  - search starts at pointer rr_ptr; the first k with req_val_i[k]=1 gets the grant;
  - after an accept, rr_ptr becomes (k+1) mod NUM_REQ;
  - with no accept, rr_ptr is unchanged.
REQ-021 req_rdy_o SHALL be all-zero when the outstanding count equals TAG_DEPTH; a same-cycle pop does not re-enable it.
REQ-022 On an accept, the next cycle SHALL have div_val_o=1 carrying the registered operands of k; otherwise div_val_o=0 (single-cycle issue pulses).
REQ-023 On an accept, tag k SHALL be pushed into the tag FIFO on the same edge; the outstanding count increments.
REQ-024 On div_val_i=1 with the FIFO non-empty, the head tag SHALL be popped, and the next cycle SHALL have res_val_o[tag]=1 and res_data_o=div_res_i (1-cycle latency).
REQ-025 On div_val_i=1 with the FIFO empty:
  - the result SHALL be dropped;
  - res_val_o stays 0;
  - err_o sets and holds until reset.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-027 Results SHALL return in issue order; the divider is in-order with fixed latency, and no reordering is performed.
REQ-028 A divisor of 0 SHALL be forwarded unchanged; the result is whatever the divider produces.
REQ-029 res_data_o SHALL hold its last value when res_val_o is 0.
REQ-030 busy_o SHALL be registered: 1 when the next-state count is nonzero or div_val_o is 1.

Reset
REQ-031 While rst_n=0, the following SHALL be 0: req_rdy_o, div_val_o, div_dividend_o, div_divisor_o, res_val_o, res_data_o, busy_o, err_o, rr_ptr, the FIFO pointers and the count.
REQ-032 Reset mid-operation SHALL discard all outstanding tags; divider results still in flight then arrive with an empty FIFO and are handled per REQ-025.

Structure
REQ-033 Package cal_angle_div_pkg SHALL hold:
  - constants DIVIDEND_W=16, DIVISOR_W=8, RES_W=24;
  - default NUM_REQ;
  - tag width as $clog2(NUM_REQ).
REQ-034 The tag FIFO SHALL be the sub-module div_tag_fifo, with parameters width and depth, push/pop/full/empty, and async active-low reset.

Verification
REQ-035 Single request: requester 2 with 1000/7, divider latency 20 -> div_val_o one cycle after the accept; res_val_o=4'b0100 one cycle after div_val_i; res_data_o = divider output.
REQ-036 All four requesters held valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; each result is routed to its issuer in that order.
REQ-037 Divider stalled with div_val_i held 0 and 40 back-to-back requests -> exactly 32 accepts, then req_rdy_o=0 with busy_o=1; the first result resumes accepts one cycle later.
REQ-038 Push and pop in the same cycle at count 5 -> count stays 5; the tag sequence is intact.
REQ-039 Pulse rst_n low with 3 operations in flight -> outputs 0; the three late div_val_i pulses are dropped; err_o=1 and stays 1.
REQ-040 Divisor 0 from requester 1 -> forwarded; res_val_o[1] asserted with the divider's value; err_o stays 0.
